// File: rtl/alu_op_arbiter.sv
// Two-requester front end for a shared registered RV32 R-type ALU.
// Round-robin arbitration, one op in flight, per-requester response buffers.
module alu_op_arbiter #(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [6:0]       req_funct7_0,
  input  logic [6:0]       req_funct7_1,
  input  logic [2:0]       req_funct3_0,
  input  logic [2:0]       req_funct3_1,
  input  logic [XLEN-1:0]  req_rs1_0,
  input  logic [XLEN-1:0]  req_rs1_1,
  input  logic [XLEN-1:0]  req_rs2_0,
  input  logic [XLEN-1:0]  req_rs2_1,
  input  logic [TAG_W-1:0] req_tag_0,
  input  logic [TAG_W-1:0] req_tag_1,
  output logic [6:0]       alu_funct7,
  output logic [2:0]       alu_funct3,
  output logic [XLEN-1:0]  alu_rs1,
  output logic [XLEN-1:0]  alu_rs2,
  input  logic [XLEN-1:0]  alu_result,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [XLEN-1:0]  resp_value_0,
  output logic [XLEN-1:0]  resp_value_1,
  output logic [TAG_W-1:0] resp_tag_0,
  output logic [TAG_W-1:0] resp_tag_1
);

  logic             inflight_v_q, inflight_v_d;
  logic             inflight_id_q, inflight_id_d;
  logic [TAG_W-1:0] tag_pipe_q, tag_pipe_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       resp_buf_v_q, resp_buf_v_d;
  logic [XLEN-1:0]  resp_value_0_q, resp_value_0_d;
  logic [XLEN-1:0]  resp_value_1_q, resp_value_1_d;
  logic [TAG_W-1:0] resp_tag_0_q, resp_tag_0_d;
  logic [TAG_W-1:0] resp_tag_1_q, resp_tag_1_d;

  logic [1:0] elig;
  logic [1:0] cand;
  logic [1:0] grant;

  // Eligibility and round-robin grant; a buffer draining this cycle may be re-targeted.
  always_comb begin
    elig[0] = !(inflight_v_q && !inflight_id_q) && (!resp_buf_v_q[0] || resp_ready[0]);
    elig[1] = !(inflight_v_q &&  inflight_id_q) && (!resp_buf_v_q[1] || resp_ready[1]);
    cand    = req_valid & elig;
    if (cand == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      grant = cand;
    end
    req_ready = grant;
  end

  // ALU operand mux; requester 0 fields drive the ALU when nothing is granted.
  always_comb begin
    if (grant[1]) begin
      alu_funct7 = req_funct7_1;
      alu_funct3 = req_funct3_1;
      alu_rs1    = req_rs1_1;
      alu_rs2    = req_rs2_1;
    end else begin
      alu_funct7 = req_funct7_0;
      alu_funct3 = req_funct3_0;
      alu_rs1    = req_rs1_0;
      alu_rs2    = req_rs2_0;
    end
  end

  // Next state: issue tracking, drain on handshake, capture of the in-flight result.
  always_comb begin
    inflight_v_d   = |grant;
    inflight_id_d  = grant[1];
    tag_pipe_d     = grant[1] ? req_tag_1 : req_tag_0;
    last_grant_d   = (|grant) ? grant[1] : last_grant_q;
    resp_buf_v_d   = resp_buf_v_q & ~resp_ready;
    resp_value_0_d = resp_value_0_q;
    resp_value_1_d = resp_value_1_q;
    resp_tag_0_d   = resp_tag_0_q;
    resp_tag_1_d   = resp_tag_1_q;
    // Capture overrides a same-cycle drain of the targeted buffer.
    if (inflight_v_q) begin
      if (inflight_id_q) begin
        resp_buf_v_d[1] = 1'b1;
        resp_value_1_d  = alu_result;
        resp_tag_1_d    = tag_pipe_q;
      end else begin
        resp_buf_v_d[0] = 1'b1;
        resp_value_0_d  = alu_result;
        resp_tag_0_d    = tag_pipe_q;
      end
    end
  end

  // State registers with synchronous reset; reset drops any in-flight or buffered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_v_q   <= 1'b0;
      inflight_id_q  <= 1'b0;
      tag_pipe_q     <= '0;
      last_grant_q   <= 1'b1;
      resp_buf_v_q   <= 2'b00;
      resp_value_0_q <= '0;
      resp_value_1_q <= '0;
      resp_tag_0_q   <= '0;
      resp_tag_1_q   <= '0;
    end else begin
      inflight_v_q   <= inflight_v_d;
      inflight_id_q  <= inflight_id_d;
      tag_pipe_q     <= tag_pipe_d;
      last_grant_q   <= last_grant_d;
      resp_buf_v_q   <= resp_buf_v_d;
      resp_value_0_q <= resp_value_0_d;
      resp_value_1_q <= resp_value_1_d;
      resp_tag_0_q   <= resp_tag_0_d;
      resp_tag_1_q   <= resp_tag_1_d;
    end
  end

  assign resp_valid   = resp_buf_v_q;
  assign resp_value_0 = resp_value_0_q;
  assign resp_value_1 = resp_value_1_q;
  assign resp_tag_0   = resp_tag_0_q;
  assign resp_tag_1   = resp_tag_1_q;

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Directed bench for alu_op_arbiter with a registered R-type ALU model behind it.
module tb_alu_op_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [6:0]  req_funct7_0, req_funct7_1;
  logic [2:0]  req_funct3_0, req_funct3_1;
  logic [31:0] req_rs1_0, req_rs1_1, req_rs2_0, req_rs2_1;
  logic [4:0]  req_tag_0, req_tag_1;
  logic [6:0]  alu_funct7;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_rs1, alu_rs2, alu_result;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_value_0, resp_value_1;
  logic [4:0]  resp_tag_0, resp_tag_1;

  int n_total = 0;
  int n_pass  = 0;

  alu_op_arbiter #(.TAG_W(5), .XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct7_0 (req_funct7_0),
    .req_funct7_1 (req_funct7_1),
    .req_funct3_0 (req_funct3_0),
    .req_funct3_1 (req_funct3_1),
    .req_rs1_0    (req_rs1_0),
    .req_rs1_1    (req_rs1_1),
    .req_rs2_0    (req_rs2_0),
    .req_rs2_1    (req_rs2_1),
    .req_tag_0    (req_tag_0),
    .req_tag_1    (req_tag_1),
    .alu_funct7   (alu_funct7),
    .alu_funct3   (alu_funct3),
    .alu_rs1      (alu_rs1),
    .alu_rs2      (alu_rs2),
    .alu_result   (alu_result),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_value_0 (resp_value_0),
    .resp_value_1 (resp_value_1),
    .resp_tag_0   (resp_tag_0),
    .resp_tag_1   (resp_tag_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU: result appears one clock after operands are presented.
  function automatic logic [31:0] alu_model(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'd0: r = f7[5] ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = {31'b0, $signed(a) < $signed(b)};
      3'd3: r = {31'b0, a < b};
      3'd4: r = a ^ b;
      3'd5: r = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) alu_result <= alu_model(alu_funct7, alu_funct3, alu_rs1, alu_rs2);

  typedef struct {
    logic        id;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] tag);
    if (id) begin
      req_funct7_1 = f7; req_funct3_1 = f3; req_rs1_1 = rs1; req_rs2_1 = rs2;
      req_tag_1 = tag; req_valid[1] = 1'b1;
    end else begin
      req_funct7_0 = f7; req_funct3_0 = f3; req_rs1_0 = rs1; req_rs2_0 = rs2;
      req_tag_0 = tag; req_valid[0] = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 2'b00;
    resp_ready = 2'b11;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    resp_ready = 2'b11;
    req_funct7_0 = '0; req_funct3_0 = '0; req_rs1_0 = '0; req_rs2_0 = '0; req_tag_0 = '0;
    req_funct7_1 = '0; req_funct3_1 = '0; req_rs1_1 = '0; req_rs2_1 = '0; req_tag_1 = '0;

    vecs[0] = '{1'b0, 7'h00, 3'd0, 32'd5,        32'd7,        5'd3,  32'd12};
    vecs[1] = '{1'b1, 7'h20, 3'd0, 32'd10,       32'd3,        5'd4,  32'd7};
    vecs[2] = '{1'b0, 7'h00, 3'd4, 32'h0000_00F0, 32'h0000_000F, 5'd5,  32'h0000_00FF};
    vecs[3] = '{1'b1, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1,        5'd6,  32'd1};
    vecs[4] = '{1'b0, 7'h00, 3'd3, 32'hFFFF_FFFF, 32'd1,        5'd7,  32'd0};
    vecs[5] = '{1'b1, 7'h20, 3'd5, 32'h8000_0000, 32'd4,        5'd8,  32'hF800_0000};
    vecs[6] = '{1'b0, 7'h00, 3'd1, 32'd3,        32'd4,        5'd9,  32'h0000_0030};
    vecs[7] = '{1'b1, 7'h00, 3'd7, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd10, 32'h0F00_0F00};
    vecs[8] = '{1'b0, 7'h00, 3'd6, 32'h1234_0000, 32'h0000_5678, 5'd11, 32'h1234_5678};
    vecs[9] = '{1'b1, 7'h00, 3'd5, 32'h8000_0000, 32'd31,       5'd31, 32'd1};

    // Reset then idle.
    do_reset();
    #1;
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_value0", resp_value_0, 32'd0);
    chk("reset_tag1", 32'(resp_tag_1), 32'd0);
    step();
    chk("idle_req_ready", 32'(req_ready), 32'd0);

    // Tie right after reset goes to requester 0, then grants alternate.
    do_reset();
    resp_ready = 2'b11;
    set_req(1'b0, 7'h20, 3'd0, 32'd10, 32'd3, 5'd1);
    set_req(1'b1, 7'h00, 3'd4, 32'h0000_00F0, 32'h0000_000F, 5'd2);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      #1;
      chk("alt_req_ready", 32'(req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
      chk("alt_resp_valid", 32'(resp_valid), (c < 2) ? 32'd0 : ((c % 2 == 0) ? 32'd1 : 32'd2));
      if (c >= 2 && c % 2 == 0) begin
        chk("alt_value0", resp_value_0, 32'd7);
        chk("alt_tag0", 32'(resp_tag_0), 32'd1);
      end
      if (c >= 3 && c % 2 == 1) begin
        chk("alt_value1", resp_value_1, 32'h0000_00FF);
        chk("alt_tag1", 32'(resp_tag_1), 32'd2);
      end
    end
    idle(4);

    // Single-requester vectors: accept at N, blocked at N+1, result at N+2.
    for (int v = 0; v < 10; v++) begin
      req_valid = 2'b00;
      set_req(vecs[v].id, vecs[v].f7, vecs[v].f3, vecs[v].rs1, vecs[v].rs2, vecs[v].tag);
      #1;
      chk("vec_accept", 32'(req_ready), vecs[v].id ? 32'd2 : 32'd1);
      step();
      #1;
      chk("vec_blocked", 32'(req_ready), 32'd0);
      chk("vec_no_early_resp", 32'(resp_valid), 32'd0);
      step();
      req_valid = 2'b00;
      #1;
      chk("vec_resp_valid", 32'(resp_valid), vecs[v].id ? 32'd2 : 32'd1);
      chk("vec_value", vecs[v].id ? resp_value_1 : resp_value_0, vecs[v].exp);
      chk("vec_tag", 32'(vecs[v].id ? resp_tag_1 : resp_tag_0), 32'(vecs[v].tag));
      step();
    end
    idle(2);

    // Backpressure on requester 1 stalls only requester 1.
    resp_ready = 2'b01;
    step();
    set_req(1'b1, 7'h00, 3'd0, 32'd100, 32'd1, 5'd9);
    #1;
    chk("bp_grant1", 32'(req_ready), 32'd2);
    step();
    set_req(1'b1, 7'h00, 3'd0, 32'd1, 32'd1, 5'd10);
    set_req(1'b0, 7'h00, 3'd0, 32'd5, 32'd7, 5'd3);
    #1;
    chk("bp_c1_ready", 32'(req_ready), 32'd1);
    for (int c = 2; c < 7; c++) begin
      step();
      #1;
      chk("bp_ready", 32'(req_ready), (c % 2 == 1) ? 32'd1 : 32'd0);
      chk("bp_valid1", 32'(resp_valid[1]), 32'd1);
      chk("bp_value1", resp_value_1, 32'd101);
      chk("bp_tag1", 32'(resp_tag_1), 32'd9);
    end
    step();
    resp_ready = 2'b11;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'd2);
    step();
    req_valid = 2'b00;
    step();
    #1;
    chk("bp_new_valid1", 32'(resp_valid[1]), 32'd1);
    chk("bp_new_value1", resp_value_1, 32'd2);
    chk("bp_new_tag1", 32'(resp_tag_1), 32'd10);
    idle(3);

    // Drain-bypass: full buffer 0 re-targeted in the cycle it drains.
    resp_ready = 2'b10;
    step();
    set_req(1'b0, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1, 5'd5);
    #1;
    chk("db_accept", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b00;
    step();
    set_req(1'b0, 7'h00, 3'd0, 32'd20, 32'd22, 5'd6);
    #1;
    chk("db_held_ready", 32'(req_ready), 32'd0);
    chk("db_held_valid", 32'(resp_valid), 32'd1);
    chk("db_held_value", resp_value_0, 32'd1);
    chk("db_held_tag", 32'(resp_tag_0), 32'd5);
    step();
    #1;
    chk("db_stable_ready", 32'(req_ready), 32'd0);
    chk("db_stable_value", resp_value_0, 32'd1);
    step();
    resp_ready = 2'b11;
    #1;
    chk("db_bypass_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b00;
    #1;
    chk("db_gap_valid", 32'(resp_valid), 32'd0);
    step();
    #1;
    chk("db_new_valid", 32'(resp_valid), 32'd1);
    chk("db_new_value", resp_value_0, 32'd42);
    chk("db_new_tag", 32'(resp_tag_0), 32'd6);
    idle(3);

    // Reset while an op is in flight: no response afterwards.
    set_req(1'b0, 7'h00, 3'd0, 32'd1, 32'd2, 5'd12);
    #1;
    chk("mr_accept", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("mr_no_resp", 32'(resp_valid), 32'd0);
      step();
    end
    chk("mr_value0", resp_value_0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
